// File: rtl/trace_run_sequencer.sv
// trace_run_sequencer
// Turns each new value from the upstream select counter into a burst of
// crypto-core runs. Every run gets a start pulse, a scope trigger window
// and a bounded wait for the core's done pulse. Per-value completion is
// pulsed on sel_done. Sweep completion (all_done) and core timeouts
// (timeout_err) are sticky until reset.
module trace_run_sequencer #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int RUNS_PER_SEL   = 8,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SEL_MAX        = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] select,
    input  logic       core_done,
    output logic       core_start,
    output logic [3:0] core_sel,
    output logic       trigger,
    output logic [7:0] run_idx,
    output logic       sel_done,
    output logic       all_done,
    output logic       timeout_err
);

    // Each counter is only as wide as its terminal value needs. Every counter
    // stops at an explicit terminal compare, so none of them can wrap.
    localparam int SW = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam int GW = (GAP_CYCLES     > 1) ? $clog2(GAP_CYCLES)     : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
    // The START cycle is the first cycle of the trigger window. Firing on
    // wait-count TIMEOUT_CYCLES-2 makes the window TIMEOUT_CYCLES long in total.
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0]    RUN_LAST    = 8'(RUNS_PER_SEL - 1);
    localparam logic [3:0]    SEL_TOP     = 4'(SEL_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT_DONE,
        GAP,
        HOLD
    } state_t;

    state_t          state_reg;
    logic [3:0]      sel_q;
    logic [3:0]      active_sel;
    logic [SW-1:0]   settle_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   to_cnt;
    logic            change;
    logic            run_end;

    // A new in-range value differing from the one being served. Out-of-range
    // selects never produce an event, so the FSM simply stays where it is.
    assign change  = (sel_q != active_sel) && (sel_q <= SEL_TOP);
    // A run ends either on the core's done pulse or on expiry of the wait.
    assign run_end = core_done || (to_cnt == TO_LAST);

    // Input register, sequencing FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            sel_q       <= 4'd0;
            active_sel  <= 4'hF;
            settle_cnt  <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            core_start  <= 1'b0;
            core_sel    <= 4'd0;
            trigger     <= 1'b0;
            run_idx     <= 8'd0;
            sel_done    <= 1'b0;
            all_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sel_q      <= select;
            core_start <= 1'b0;
            sel_done   <= 1'b0;
            case (state_reg)
                IDLE, HOLD: begin
                    if (change) begin
                        state_reg  <= SETTLE;
                        active_sel <= sel_q;
                        core_sel   <= sel_q;
                        run_idx    <= 8'd0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (change) begin
                        // A newer value restarts the settle period from scratch.
                        active_sel <= sel_q;
                        core_sel   <= sel_q;
                        run_idx    <= 8'd0;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state_reg  <= START;
                        core_start <= 1'b1;
                        trigger    <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                START: begin
                    state_reg <= WAIT_DONE;
                    to_cnt    <= '0;
                end
                WAIT_DONE: begin
                    if (run_end) begin
                        trigger <= 1'b0;
                        if (!core_done) begin
                            timeout_err <= 1'b1;
                        end
                        if (run_idx == RUN_LAST) begin
                            // All runs are done. HOLD picks up any pending change.
                            sel_done  <= 1'b1;
                            state_reg <= HOLD;
                            if (active_sel == SEL_TOP) begin
                                all_done <= 1'b1;
                            end
                        end else if (change) begin
                            // A new value arrived during this run. Drop the remaining runs.
                            state_reg  <= SETTLE;
                            active_sel <= sel_q;
                            core_sel   <= sel_q;
                            run_idx    <= 8'd0;
                            settle_cnt <= '0;
                        end else begin
                            state_reg <= GAP;
                            run_idx   <= run_idx + 8'd1;
                            gap_cnt   <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (change) begin
                        state_reg  <= SETTLE;
                        active_sel <= sel_q;
                        core_sel   <= sel_q;
                        run_idx    <= 8'd0;
                        settle_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state_reg  <= START;
                        core_start <= 1'b1;
                        trigger    <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/trace_run_sequencer.md
Name: trace_run_sequencer

Overview:
- Sits directly downstream of the select counter; consumes its 4-bit select (steps 0..9, one step per ~1.56M cycles).
- For each new select value, issues a fixed number of start pulses to the crypto core, carrying the selected key/plaintext index, and waits for the core's done handshake on each run.
- Drives the scope trigger window around every run.
- Reports per-value and whole-sweep completion, plus a sticky timeout error.

Parameters:
- SETTLE_CYCLES, 16, idle cycles after a select change before the first run.
- RUNS_PER_SEL, 8, core runs issued per select value (1..255).
- GAP_CYCLES, 1000, idle cycles between consecutive runs (>=1).
- TIMEOUT_CYCLES, 4096, maximum cycles waiting for core_done after core_start.
- SEL_MAX, 9, highest valid select value; completing it sets all_done.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- select  in  4  index from the upstream select counter.
- core_done  in  1  one-cycle pulse from the crypto core at end of operation.
- core_start  out  1  one-cycle start pulse to the crypto core.
- core_sel  out  4  index presented to the core; stable from START through WAIT_DONE.
- trigger  out  1  scope trigger, high from START through the cycle core_done is seen.
- run_idx  out  8  index of the current run within the current select value (0-based).
- sel_done  out  1  one-cycle pulse when all runs for the current value finish.
- all_done  out  1  sticky; set when the runs for SEL_MAX complete.
- timeout_err  out  1  sticky; set on any core timeout.

Behaviour:
- Reset values:
  - Outputs: core_start=0, core_sel=0, trigger=0, run_idx=0, sel_done=0, all_done=0, timeout_err=0.
  - State: FSM=IDLE; sel_q=0; active_sel=4'hF, so the first valid select after reset counts as a change.
- Input stage: select is registered into sel_q every cycle. A change event is sel_q != active_sel with sel_q <= SEL_MAX. Values > SEL_MAX are ignored and the FSM stays in place.
- States: IDLE, SETTLE, START, WAIT_DONE, GAP, HOLD.
- IDLE/HOLD -> SETTLE on a change event, same edge:
  - active_sel<=sel_q, core_sel<=sel_q, run_idx<=0, settle counter cleared.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then goes to START.
  - A further change event reloads active_sel/core_sel and restarts the count.
- START (exactly one cycle):
  - core_start=1 and trigger=1.
  - Timeout counter cleared.
  - Next state WAIT_DONE.
- WAIT_DONE:
  - trigger held high.
  - On core_done: trigger falls the next cycle, and the run is complete.
  - If the counter reaches TIMEOUT_CYCLES without core_done: timeout_err<=1, trigger falls, and the run counts as complete.
  - core_done arriving in any other state is ignored.
- Run complete:
  - If run_idx == RUNS_PER_SEL-1: pulse sel_do for one cycle; if active_sel == SEL_MAX, set all_done; go to HOLD. run_idx stays at its final value.
  - Otherwise: run_idx increments and the FSM goes to GAP.
- GAP:
  - Counts GAP_CYCLES, then goes to START.
  - If a change event is pending, go instead to SETTLE for the new value; the remaining runs are abandoned and sel_done is not pulsed.
- Change during WAIT_DONE: the current run finishes or times out first, then the FSM goes to SETTLE for the new value; no further runs of the old value are issued.
- Wrap-around: upstream select returning to 0 after 9 is a normal change event. all_done stays set; only reset clears it.
- Counter widths: sized by clog2 of each parameter; no counter may wrap silently.

Test Plan:
- Reset, then hold select=0, SETTLE=4, RUNS=3, GAP=5; core_done 10 cycles after each start -> exactly 3 core_start pulses with core_sel=0 and run_idx 0,1,2; trigger width 11 cycles; a single sel_done pulse; FSM in HOLD.
- Sweep select 0..9 with a long dwell on each value -> 30 starts; all_done rises on the cycle after the last run of select=9; stepping select to 0 afterwards restarts runs while all_done stays 1.
- core_done never asserted, TIMEOUT=64 -> trigger high 64 cycles then low; timeout_err=1 and stays 1; the next run still starts after GAP.
- Select changes 0->1 during the GAP after run 0 -> no further core_sel=0 starts; no sel_done for value 0; SETTLE then 3 runs with core_sel=1.
- select=12 applied from HOLD -> no starts and outputs unchanged; a later select=3 -> normal 3-run sequence.
- Reset asserted mid WAIT_DONE -> all outputs at reset values the next cycle; a later core_done is ignored; the sequence restarts for the current select after SETTLE.
